// File: rtl/rv_constants.sv
// ---------------------------------------------------------------------------
// rv_constants
// Shared constants for the ALU datapath: the ALU_* function codes driven by
// the ALU controller, the serial ALU FSM state encoding, and a small decode
// helper for recognising the iterative shift operations.
// ---------------------------------------------------------------------------
package rv_constants;

    // ALU function codes (5-bit alu_function field)
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_SEQ  = 5'd10;

    // Serial ALU control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    // True for the three operations that run through the iterative shifter
    function automatic logic is_shift_op(input logic [4:0] fn);
        return (fn == ALU_SLL) || (fn == ALU_SRL) || (fn == ALU_SRA);
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// ---------------------------------------------------------------------------
// serial_shifter
// One-bit-per-cycle shifter. A load captures the source word, the shift
// count and the direction/arithmetic controls; afterwards the working word
// moves by one bit every cycle while the counter is non-zero.
//
// Ports
//   clock       : rising-edge clock
//   reset       : synchronous active-high reset (clears word and counter)
//   load        : capture load_data / load_count / direction controls
//   load_left   : 1 = shift left (SLL), 0 = shift right
//   load_arith  : right shifts replicate the sign bit (SRA) when set
//   load_data   : word to be shifted
//   load_count  : number of single-bit steps to perform
//   step_data   : working word after the step taken this cycle
//   last_step   : this cycle performs the final step (counter == 1)
// ---------------------------------------------------------------------------
module serial_shifter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   load_left,
    input  logic                   load_arith,
    input  logic [DATA_WIDTH-1:0]  load_data,
    input  logic [SHAMT_WIDTH-1:0] load_count,
    output logic [DATA_WIDTH-1:0]  step_data,
    output logic                   last_step
);

    logic [DATA_WIDTH-1:0]  work;
    logic [SHAMT_WIDTH-1:0] count;
    logic                   shift_left;
    logic                   shift_arith;
    logic                   fill_bit;

    // Right shifts fill with the sign bit only for arithmetic shifts
    assign fill_bit  = shift_arith & work[DATA_WIDTH-1];
    assign step_data = shift_left ? {work[DATA_WIDTH-2:0], 1'b0}
                                  : {fill_bit, work[DATA_WIDTH-1:1]};
    assign last_step = (count == SHAMT_WIDTH'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            work        <= '0;
            count       <= '0;
            shift_left  <= 1'b0;
            shift_arith <= 1'b0;
        end else if (load) begin
            work        <= load_data;
            count       <= load_count;
            shift_left  <= load_left;
            shift_arith <= load_arith;
        end else if (count != '0) begin
            work  <= step_data;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/serial_alu.sv
// ---------------------------------------------------------------------------
// serial_alu
// Small ALU with a valid/ready handshake. Arithmetic, logic and compare
// operations finish in the accept cycle (result one cycle later); SLL, SRL
// and SRA with a non-zero amount iterate one bit per cycle in
// serial_shifter. The result is held until the consumer takes it.
//
// Ports
//   clock             : rising-edge clock
//   reset             : synchronous active-high reset
//   alu_function      : ALU_* operation code
//   operand_a         : first operand / shift source
//   operand_b         : second operand; low SHAMT_WIDTH bits = shift amount
//   in_valid/in_ready : request handshake (ready only in IDLE)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   result            : registered operation result
//   result_equal_zero : high when the registered result is zero
// ---------------------------------------------------------------------------
module serial_alu
    import rv_constants::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4:0]            alu_function,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_equal_zero
);

    alu_state_t             state;
    alu_state_t             state_next;
    logic [DATA_WIDTH-1:0]  result_q;
    logic [DATA_WIDTH-1:0]  result_next;
    logic                   result_load;
    logic                   shift_load;
    logic                   shift_last;
    logic [DATA_WIDTH-1:0]  shift_step;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   accept;

    // Zero-extend a single compare flag to a full result word
    function automatic logic [DATA_WIDTH-1:0] flag_word(input logic flag);
        return {{(DATA_WIDTH-1){1'b0}}, flag};
    endfunction

    // Single-cycle operations. Shift codes land here only with a zero
    // amount, where the result is the unshifted source.
    function automatic logic [DATA_WIDTH-1:0] alu_single(
        input logic [4:0]            fn,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH-1:0] a_s;
        logic signed [DATA_WIDTH-1:0] b_s;
        logic [DATA_WIDTH-1:0]        r;
        a_s = a;
        b_s = b;
        case (fn)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_XOR:  r = a ^ b;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_SLT:  r = flag_word(a_s < b_s);
            ALU_SLTU: r = flag_word(a < b);
            ALU_SEQ:  r = flag_word(a == b);
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  r = a;
            default:  r = '0;
        endcase
        return r;
    endfunction

    assign shamt             = operand_b[SHAMT_WIDTH-1:0];
    assign in_ready          = (state == IDLE);
    assign out_valid         = (state == DONE);
    assign accept            = in_valid && in_ready;
    assign result            = result_q;
    assign result_equal_zero = (result_q == '0);

    serial_shifter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_shifter (
        .clock      (clock),
        .reset      (reset),
        .load       (shift_load),
        .load_left  (alu_function == ALU_SLL),
        .load_arith (alu_function == ALU_SRA),
        .load_data  (operand_a),
        .load_count (shamt),
        .step_data  (shift_step),
        .last_step  (shift_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            result_q <= '0;
        end else begin
            state <= state_next;
            if (result_load) begin
                result_q <= result_next;
            end
        end
    end

    always_comb begin
        state_next  = state;
        result_load = 1'b0;
        result_next = result_q;
        shift_load  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_shift_op(alu_function) && (shamt != '0)) begin
                        shift_load = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        result_load = 1'b1;
                        result_next = alu_single(alu_function, operand_a, operand_b);
                        state_next  = DONE;
                    end
                end
            end
            SHIFT: begin
                // The final step's output is captured directly so the result
                // is ready in the cycle DONE is entered.
                if (shift_last) begin
                    result_load = 1'b1;
                    result_next = shift_step;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_alu.sv
// ---------------------------------------------------------------------------
// tb_serial_alu
// Directed bench for serial_alu: reset state, single-cycle operations,
// iterative shifts with their latencies, result hold under back-pressure,
// request blocking outside IDLE, and reset abort during a shift.
// ---------------------------------------------------------------------------
module tb_serial_alu;
    import rv_constants::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  alu_function;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        result_equal_zero;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [4:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       tag;
    } vec_t;

    vec_t tbl[$];

    serial_alu #(
        .DATA_WIDTH  (32),
        .SHAMT_WIDTH (5)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .alu_function      (alu_function),
        .operand_a         (operand_a),
        .operand_b         (operand_b),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .result            (result),
        .result_equal_zero (result_equal_zero)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for out_valid; n is the number of cycles after the accept edge
    task automatic wait_valid(input string tag, output int n);
        n = 1;
        while (out_valid !== 1'b1 && n < 200) begin
            check({tag, ".busy_ready"}, {31'b0, in_ready}, 32'd0);
            step();
            n++;
        end
    endtask

    // Issue one request, scramble the inputs after accept, check latency and
    // result, then retire it.
    task automatic run(input vec_t v);
        int n;
        check({v.tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        alu_function = v.fn;
        operand_a    = v.a;
        operand_b    = v.b;
        in_valid     = 1'b1;
        step();
        in_valid     = 1'b0;
        alu_function = ALU_AND;
        operand_a    = ~v.a;
        operand_b    = 32'h5A5A_5A5A;
        wait_valid(v.tag, n);
        check({v.tag, ".latency"}, n, v.lat);
        check({v.tag, ".result"}, result, v.exp);
        check({v.tag, ".zero"}, {31'b0, result_equal_zero}, {31'b0, v.exp == 32'd0});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({v.tag, ".retired"}, {31'b0, out_valid}, 32'd0);
    endtask

    function automatic vec_t mk(input string tag, input logic [4:0] fn, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp, input int lat);
        vec_t v;
        v.tag = tag; v.fn = fn; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    initial begin
        int n;
        reset        = 1'b1;
        alu_function = ALU_ADD;
        operand_a    = '0;
        operand_b    = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;

        // Reset state
        step();
        step();
        reset = 1'b0;
        check("rst.in_ready", {31'b0, in_ready}, 32'd1);
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.zero", {31'b0, result_equal_zero}, 32'd1);

        // Directed vectors with hand-computed results and latencies
        tbl.push_back(mk("add_wrap",  ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1));
        tbl.push_back(mk("sra4",      ALU_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5));
        tbl.push_back(mk("slt_neg",   ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1));
        tbl.push_back(mk("sltu_big",  ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1));
        tbl.push_back(mk("seq_eq",    ALU_SEQ,  32'h0000_1234, 32'h0000_1234, 32'h0000_0001, 1));
        tbl.push_back(mk("sub_neg",   ALU_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1));
        tbl.push_back(mk("sub_zero",  ALU_SUB,  32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 1));
        tbl.push_back(mk("xor",       ALU_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1));
        tbl.push_back(mk("or",        ALU_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1));
        tbl.push_back(mk("and",       ALU_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1));
        tbl.push_back(mk("slt_pos",   ALU_SLT,  32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0000, 1));
        tbl.push_back(mk("slt_min",   ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1));
        tbl.push_back(mk("sltu_lt",   ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1));
        tbl.push_back(mk("seq_ne",    ALU_SEQ,  32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1));
        tbl.push_back(mk("unknown",   5'd31,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1));
        tbl.push_back(mk("sll_k0",    ALU_SLL,  32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1));
        tbl.push_back(mk("sra_k0",    ALU_SRA,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1));
        tbl.push_back(mk("srl31",     ALU_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 32));
        tbl.push_back(mk("sra1",      ALU_SRA,  32'h7FFF_FFFF, 32'h0000_0001, 32'h3FFF_FFFF, 2));
        tbl.push_back(mk("sra31",     ALU_SRA,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 32));
        tbl.push_back(mk("sll4",      ALU_SLL,  32'h0000_000F, 32'h0000_0004, 32'h0000_00F0, 5));
        tbl.push_back(mk("srl28",     ALU_SRL,  32'hF000_0000, 32'h0000_001C, 32'h0000_000F, 29));
        foreach (tbl[i]) run(tbl[i]);

        // SLL 1 by 31 with back-pressure; a second request stays pending
        alu_function = ALU_SLL;
        operand_a    = 32'h0000_0001;
        operand_b    = 32'd31;
        in_valid     = 1'b1;
        step();
        alu_function = ALU_ADD;
        operand_a    = 32'd5;
        operand_b    = 32'd5;
        wait_valid("hold", n);
        check("hold.latency", n, 32);
        check("hold.result", result, 32'h8000_0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold.valid", {31'b0, out_valid}, 32'd1);
            check("hold.stable", result, 32'h8000_0000);
            check("hold.zero", {31'b0, result_equal_zero}, 32'd0);
            check("hold.ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hold.idle_ready", {31'b0, in_ready}, 32'd1);
        check("hold.no_accept", {31'b0, out_valid}, 32'd0);
        step();
        in_valid = 1'b0;
        check("pend.valid", {31'b0, out_valid}, 32'd1);
        check("pend.result", result, 32'h0000_000A);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // SRL aborted by reset three cycles after accept
        alu_function = ALU_SRL;
        operand_a    = 32'hFFFF_FFFF;
        operand_b    = 32'd16;
        in_valid     = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort.in_ready", {31'b0, in_ready}, 32'd1);
        check("abort.result", result, 32'd0);
        check("abort.zero", {31'b0, result_equal_zero}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            check("abort.no_valid", {31'b0, out_valid}, 32'd0);
            step();
        end

        // Shifter counter cleared by the abort: a fresh request works
        run(mk("post_abort", ALU_ADD, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the operand and result width.
REQ-002 SHALL have parameter SHAMT_WIDTH, default 5, the shift-amount width (log2 DATA_WIDTH).
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port alu_function  input  5  operation code, encoded per the ALU_* constants driven by the ALU controller.
REQ-006 SHALL have port operand_a  input  DATA_WIDTH  first operand / shift source.
REQ-007 SHALL have port operand_b  input  DATA_WIDTH  second operand; bits [SHAMT_WIDTH-1:0] are the shift amount.
REQ-008 SHALL have port in_valid  input  1  request present.
REQ-009 SHALL have port in_ready  output  1  block can accept a request.
REQ-010 SHALL have port out_valid  output  1  result held on result.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port result  output  DATA_WIDTH  operation result.
REQ-013 SHALL have port result_equal_zero  output  1  high when result == 0.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = (state == IDLE).
REQ-015 SHALL accept a request when in_valid && in_ready, capturing alu_function, operands and shift amount into registers.
REQ-016 On accept of ADD, SUB, XOR, OR, AND, SLT, SLTU, SEQ, or unknown code: SHALL compute in the accept cycle and enter DONE, out_valid high next cycle (latency 1).
REQ-017 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH; SLT signed, SLTU unsigned, SEQ (a == b), each zero-extended 1-bit result.
REQ-018 Unknown alu_function codes SHALL yield result 0.
REQ-019 On accept of SLL, SRL, SRA with shift amount k > 0: SHALL enter SHIFT, loading a down-counter with k.
REQ-020 In SHIFT: SHALL shift the working register by exactly one bit per cycle (SRA replicates the sign bit, SRL/SLL fill 0) and decrement the counter; on the cycle the counter reaches 1, SHALL enter DONE.
REQ-021 Shift with k = 0 SHALL behave as REQ-016 and return operand_a unchanged; shift with k SHALL have out_valid high k+1 cycles after accept.
REQ-022 In DONE: out_valid = 1; result and result_equal_zero SHALL be stable until out_ready is sampled high.
REQ-023 DONE with out_ready high SHALL return to IDLE next cycle; no new request is accepted in that same cycle.
REQ-024 in_valid SHALL be ignored outside IDLE; operand changes after accept SHALL not affect the result.
REQ-025 result_equal_zero SHALL be derived from the registered result, never from live operands.

Reset
REQ-026 While reset is high at a clock edge, state SHALL go to IDLE, out_valid 0, result 0, result_equal_zero 1, counter 0.
REQ-027 Reset asserted in SHIFT or DONE SHALL abort the operation with no result delivered; in_ready high the cycle after reset deasserts.

Structure
REQ-028 ALU_* function codes SHALL come from the shared rv_constants package; the FSM state enum SHALL live in that package alongside them.
REQ-029 The iterative shifter (working register, counter, direction/arith control) SHALL be a sub-module named serial_shifter; serial_alu holds the FSM, handshake and single-cycle datapath.

Verification
REQ-030 ADD a=0xFFFFFFFF, b=1 -> out_valid 1 cycle after accept, result 0x00000000, result_equal_zero 1.
REQ-031 SRA a=0x80000000, b=4 -> out_valid 5 cycles after accept, result 0xF8000000; in_ready low throughout.
REQ-032 SLT a=0xFFFFFFFF, b=0 -> result 1; SLTU same operands -> result 0; SEQ a=b=0x1234 -> result 1.
REQ-033 SLL a=0x1, b=31 held with out_ready low for 3 cycles -> result 0x80000000 stable, out_valid high, second in_valid ignored until IDLE.
REQ-034 SRL a=0xFFFFFFFF, b=16, reset pulsed 3 cycles after accept -> out_valid never asserted, result 0, in_ready high after reset.
REQ-035 Random back-to-back requests vs. reference model for all eleven codes and k in 0..31 -> every result matches, latency per REQ-016/REQ-021.
